param_updown_counter: RTL

Parametrised up/down counter; next generation of the 4-bit up/down counter. Adds configurable width and terminal value, wrap or saturate mode, synchronous load, count enable, terminal flags and one-cycle overflow/underflow pulses. Used as a general event/credit counter across the design, with the complement output retained for the existing consumers.

---
 rtl/udc_pkg.sv | 24 ++
 rtl/param_updown_counter_if.sv | 41 ++++
 rtl/udc_next_value.sv | 54 +++++
 rtl/param_updown_counter.sv | 103 ++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Optional feature macro: UDC_STEP_EN (variable step size port).
package udc_pkg;

  localparam int unsigned UDC_MAX_W = 32;

  typedef enum logic {
    UDC_WRAP = 1'b0,
    UDC_SAT  = 1'b1
  } udc_mode_e;

  typedef enum logic [1:0] {
    UDC_DIR_HOLD = 2'd0,
    UDC_DIR_UP   = 2'd1,
    UDC_DIR_DOWN = 2'd2
  } udc_dir_e;

  // Load values above the terminal count are pulled back to it.
  function automatic logic [UDC_MAX_W-1:0] udc_clamp_load(input logic [UDC_MAX_W-1:0] val,
                                                          input logic [UDC_MAX_W-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Request/status bundle between a counter user (master) and the counter (slave).
// The step field exists only when UDC_STEP_EN is defined.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef UDC_STEP_EN
  logic [WIDTH-1:0] step;
`endif
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] inverted_cnt;
  logic             at_max;
  logic             at_min;
  logic             ovf;
  logic             unf;

`ifdef UDC_STEP_EN
  modport master (
    output en, up, down, load, load_val, step,
    input  cnt, inverted_cnt, at_max, at_min, ovf, unf
  );
  modport slave (
    input  en, up, down, load, load_val, step,
    output cnt, inverted_cnt, at_max, at_min, ovf, unf
  );
`else
  modport master (
    output en, up, down, load, load_val,
    input  cnt, inverted_cnt, at_max, at_min, ovf, unf
  );
  modport slave (
    input  en, up, down, load, load_val,
    output cnt, inverted_cnt, at_max, at_min, ovf, unf
  );
`endif

endinterface

// File: rtl/udc_next_value.sv
// Combinational next-count calculation for one step in a given direction.
// Used with or without UDC_STEP_EN; step is already clamped to MAX_VAL+1 by the caller.
module udc_next_value
  import udc_pkg::*;
#(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     MAX_VAL = '1,
  parameter udc_mode_e            MODE    = UDC_WRAP
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH:0]   step,
  input  udc_dir_e         dir,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [W1-1:0] MAX_EXT = W1'(MAX_VAL);
  localparam logic [W1-1:0] MODULUS = MAX_EXT + W1'(1);

  logic [W1-1:0] cnt_ext;
  logic [W1-1:0] sum;

  assign cnt_ext = W1'(cnt);
  assign sum     = cnt_ext + step;

  // Wider arithmetic keeps the crossing visible before any truncation.
  always_comb begin
    nxt = cnt;
    ovf = 1'b0;
    unf = 1'b0;
    case (dir)
      UDC_DIR_UP: begin
        if (sum <= MAX_EXT) begin
          nxt = WIDTH'(sum);
        end else begin
          ovf = 1'b1;
          nxt = (MODE == UDC_WRAP) ? WIDTH'(sum - MODULUS) : MAX_VAL;
        end
      end
      UDC_DIR_DOWN: begin
        if (cnt_ext >= step) begin
          nxt = WIDTH'(cnt_ext - step);
        end else begin
          unf = 1'b1;
          nxt = (MODE == UDC_WRAP) ? WIDTH'(cnt_ext + MODULUS - step) : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, enable, wrap/saturate and ovf/unf pulses.
// Define UDC_STEP_EN to add a per-request step size on the bus.
module param_updown_counter
  import udc_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter udc_mode_e        MODE    = UDC_WRAP
) (
  input  logic                         clk,
  input  logic                         reset,
  param_updown_counter_if.slave        bus
);

  localparam int unsigned W1 = WIDTH + 1;

  if (WIDTH < 2 || WIDTH > UDC_MAX_W) begin : g_bad_width
    $error("param_updown_counter: WIDTH out of range 2..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL must be at least 1");
  end

  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_d;
  logic             unf_d;

  logic [W1-1:0]    step_s;
  logic [WIDTH-1:0] load_clamped;
  udc_dir_e         dir;
  logic [WIDTH-1:0] nv_cnt;
  logic             nv_ovf;
  logic             nv_unf;

`ifdef UDC_STEP_EN
  // Oversized steps behave like a full lap of the counting range.
  assign step_s = (W1'(bus.step) > W1'(MAX_VAL)) ? (W1'(MAX_VAL) + W1'(1)) : W1'(bus.step);
`else
  assign step_s = W1'(1);
`endif

  assign load_clamped = WIDTH'(udc_clamp_load(UDC_MAX_W'(bus.load_val), UDC_MAX_W'(MAX_VAL)));

  // Conflicting or disabled requests resolve to hold.
  always_comb begin
    dir = UDC_DIR_HOLD;
    if (bus.en && bus.up && !bus.down) begin
      dir = UDC_DIR_UP;
    end else if (bus.en && bus.down && !bus.up) begin
      dir = UDC_DIR_DOWN;
    end
  end

  udc_next_value #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE)
  ) u_next (
    .cnt  (cnt_q),
    .step (step_s),
    .dir  (dir),
    .nxt  (nv_cnt),
    .ovf  (nv_ovf),
    .unf  (nv_unf)
  );

  // Load wins over counting and never raises a pulse.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (bus.load) begin
      cnt_d = load_clamped;
    end else begin
      cnt_d = nv_cnt;
      ovf_d = nv_ovf;
      unf_d = nv_unf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.cnt          = cnt_q;
  assign bus.inverted_cnt = ~cnt_q;
  assign bus.at_max       = (cnt_q == MAX_VAL);
  assign bus.at_min       = (cnt_q == '0);
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;

endmodule
